// File: rtl/cwt_pingpong_buf.sv
// Ping-pong frame buffer between the CWT multiplier and the IFFT: captures one
// N-sample complex frame per scale and replays it over valid/ready. Optional: BITREV_EN.
module cwt_pingpong_buf #(
  parameter int N  = 1024,
  parameter int J1 = 4,
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid_i,
  input  logic [DW-1:0]         in_re_i,
  input  logic [DW-1:0]         in_im_i,
  output logic                  busy_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DW-1:0]         out_re_o,
  output logic [DW-1:0]         out_im_o,
  output logic                  out_last_o,
  output logic [$clog2(J1)-1:0] out_scale_o,
  output logic                  run_done_o,
  output logic                  overflow_o
);

  localparam int AW = $clog2(N);
  localparam int SW = $clog2(J1);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

  state_t          state, state_n;
  logic [AW-1:0]   wr_cnt, rd_cnt, rd_cnt_n, rd_idx, rd_addr;
  logic            wr_bank, wr_bank_n, rd_bank;
  logic [1:0]      full, full_n;
  logic            wr_en, wr_fill, xfer, last_xfer, rd_en, valid_n;
  logic [2*DW-1:0] mem [2*N];
  logic [2*DW-1:0] rd_data;

  assign wr_en     = in_valid_i & ~busy_o;
  assign wr_fill   = wr_en & (wr_cnt == AW'(N-1));
  assign xfer      = out_valid_o & out_ready_i;
  assign last_xfer = xfer & (rd_cnt == AW'(N-1));
  assign wr_bank_n = wr_bank ^ wr_fill;

  // Fill and release always hit different banks, so both updates can apply together.
  always_comb begin
    full_n = full;
    if (wr_fill)   full_n[wr_bank] = 1'b1;
    if (last_xfer) full_n[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      full       <= 2'b00;
      busy_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (wr_en) wr_cnt <= wr_cnt + AW'(1);
      wr_bank    <= wr_bank_n;
      full       <= full_n;
      busy_o     <= full_n[wr_bank_n];
      overflow_o <= overflow_o | (in_valid_i & busy_o);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_cnt}] <= {in_re_i, in_im_i};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  // The RAM output register is the output stage; a read is only issued when the
  // presented sample is consumed, so a stall simply holds it.
  always_comb begin
    state_n  = state;
    rd_en    = 1'b0;
    rd_idx   = '0;
    rd_cnt_n = rd_cnt;
    valid_n  = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank]) state_n = FETCH;
      end
      FETCH: begin
        rd_en    = 1'b1;
        rd_cnt_n = '0;
        valid_n  = 1'b1;
        state_n  = STREAM;
      end
      STREAM: begin
        valid_n = 1'b1;
        if (last_xfer) begin
          rd_cnt_n = '0;
          valid_n  = 1'b0;
          state_n  = full[~rd_bank] ? FETCH : IDLE;
        end else if (xfer) begin
          rd_en    = 1'b1;
          rd_idx   = rd_cnt + AW'(1);
          rd_cnt_n = rd_idx;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef BITREV_EN
  function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction
  assign rd_addr = bit_rev(rd_idx);
`else
  assign rd_addr = rd_idx;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data     <= '0;
      rd_cnt      <= '0;
      rd_bank     <= 1'b0;
      out_valid_o <= 1'b0;
      out_scale_o <= '0;
      run_done_o  <= 1'b0;
    end else begin
      if (rd_en) rd_data <= mem[{rd_bank, rd_addr}];
      rd_cnt      <= rd_cnt_n;
      out_valid_o <= valid_n;
      run_done_o  <= last_xfer & (out_scale_o == SW'(J1-1));
      if (last_xfer) begin
        rd_bank     <= ~rd_bank;
        out_scale_o <= (out_scale_o == SW'(J1-1)) ? '0 : out_scale_o + SW'(1);
      end
    end
  end

  assign out_re_o   = rd_data[2*DW-1:DW];
  assign out_im_o   = rd_data[DW-1:0];
  assign out_last_o = out_valid_o & (rd_cnt == AW'(N-1));

endmodule

// File: tb/tb_cwt_pingpong_buf.sv
// Scoreboard bench for cwt_pingpong_buf: directed frames push expected samples,
// a negedge monitor pops and compares every transfer and checks stall stability.
module tb_cwt_pingpong_buf;

  localparam int N  = 1024;
  localparam int J1 = 4;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int SW = 2;
  localparam int WW = 2*DW + 1 + SW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid_i = 1'b0;
  logic [DW-1:0] in_re_i = '0;
  logic [DW-1:0] in_im_i = '0;
  logic          busy_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] out_re_o;
  logic [DW-1:0] out_im_o;
  logic          out_last_o;
  logic [SW-1:0] out_scale_o;
  logic          run_done_o;
  logic          overflow_o;

  int checks = 0;
  int errors = 0;
  int run_done_cnt = 0;
  int ready_mode = 1;
  int out_idx = 0;
  logic [WW-1:0] sb [$];

  cwt_pingpong_buf #(.N(N), .J1(J1), .DW(DW)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid_i(in_valid_i), .in_re_i(in_re_i), .in_im_i(in_im_i),
    .busy_o(busy_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_re_o(out_re_o), .out_im_o(out_im_o), .out_last_o(out_last_o),
    .out_scale_o(out_scale_o), .run_done_o(run_done_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "[TB] watchdog timeout");
  end

  // Ready driver: 0 = held low, 1 = held high, 2 = pattern 1,0,0,1.
  initial begin
    int phase;
    logic [3:0] pat;
    phase = 0;
    pat = 4'b1001;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready_i = 1'b0;
        1: out_ready_i = 1'b1;
        default: begin
          out_ready_i = pat[3-phase];
          phase = (phase + 1) % 4;
        end
      endcase
    end
  end

  // Monitor: compare each transfer against the scoreboard and check stalled outputs hold.
  initial begin
    logic [WW-1:0] got, exp_w, prev_w;
    logic prev_stall;
    prev_stall = 1'b0;
    prev_w = '0;
    forever begin
      @(negedge clk);
      got = {out_re_o, out_im_o, out_last_o, out_scale_o};
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!out_valid_o || got !== prev_w) begin
            errors++;
            $display("[TB] FAIL stall_hold: got valid=%0b word=%0h required valid=1 word=%0h",
                     out_valid_o, got, prev_w);
          end
        end
        if (out_valid_o && out_ready_i) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_out: got word=%0h with no sample expected", got);
          end else begin
            exp_w = sb.pop_front();
            if (got !== exp_w) begin
              errors++;
              $display("[TB] FAIL sample[%0d]: got %0h required %0h", out_idx, got, exp_w);
            end
          end
          out_idx++;
        end
        prev_stall = out_valid_o && !out_ready_i;
        prev_w = got;
      end
      if (run_done_o) run_done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic int bitrev(input int k);
    int r;
    r = 0;
    for (int i = 0; i < AW; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  // Writes count samples (re=base+k, im=-(base+k)), honouring busy_o; a full
  // frame also pushes its expected read-back order.
  task automatic applyStimulus(input int base, input int count, input int scale, input bit push);
    int budget, idx, v;
    for (int k = 0; k < count; k++) begin
      budget = 20000;
      while (busy_o && budget > 0) begin
        in_valid_i = 1'b0;
        tick();
        budget--;
      end
      if (budget == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL write_wait: busy_o=1 held, required release before sample %0d", k);
      end
      in_valid_i = 1'b1;
      in_re_i = base + k;
      in_im_i = -(base + k);
      tick();
    end
    in_valid_i = 1'b0;
    if (push) begin
      for (int k = 0; k < N; k++) begin
`ifdef BITREV_EN
        idx = bitrev(k);
`else
        idx = k;
`endif
        v = base + idx;
        sb.push_back({DW'(v), DW'(-v), (k == N-1), SW'(scale)});
      end
    end
  endtask

  task automatic waitDrain(input string name);
    int budget;
    budget = 20000;
    while (sb.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: %0d samples outstanding, required 0", name, sb.size());
    end
    repeat (4) tick();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"},    WW'(out_valid_o), '0);
    checkOutput({tag, "_busy"},     WW'(busy_o), '0);
    checkOutput({tag, "_last"},     WW'(out_last_o), '0);
    checkOutput({tag, "_scale"},    WW'(out_scale_o), '0);
    checkOutput({tag, "_run_done"}, WW'(run_done_o), '0);
    checkOutput({tag, "_overflow"}, WW'(overflow_o), '0);
    checkOutput({tag, "_data"},     WW'({out_re_o, out_im_o}), '0);
  endtask

  task automatic doReset(input string tag);
    rstn = 1'b0;
    in_valid_i = 1'b0;
    sb.delete();
    tick();
    tick();
    checkResetState(tag);
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    bit found;
    // Single frame with timing of the first valid
    ready_mode = 1;
    doReset("rst0");
    applyStimulus(0, N, 0, 1'b1);
    checkOutput("valid_after_fill_0", WW'(out_valid_o), '0);
    tick();
    checkOutput("valid_after_fill_1", WW'(out_valid_o), '0);
    tick();
    checkOutput("valid_after_fill_2", WW'(out_valid_o), WW'(1));
    checkOutput("single_busy", WW'(busy_o), '0);
    waitDrain("single_drain");
    checkOutput("single_busy_end", WW'(busy_o), '0);

    // Full run of J1 back-to-back frames
    doReset("rst1");
    run_done_cnt = 0;
    for (int f = 0; f < J1; f++) applyStimulus(f * N, N, f, 1'b1);
    waitDrain("run_drain");
    checkOutput("run_done_count", WW'(run_done_cnt), WW'(1));
    checkOutput("run_overflow", WW'(overflow_o), '0);

    // Backpressure with ready pattern 1,0,0,1
    ready_mode = 2;
    applyStimulus(8192, N, 0, 1'b1);
    applyStimulus(9216, N, 1, 1'b1);
    waitDrain("bp_drain");
    ready_mode = 1;

    // Consumer stall, busy timing and overflow
    doReset("rst2");
    ready_mode = 0;
    tick();
    applyStimulus(65536, N, 0, 1'b1);
    applyStimulus(66560, N, 1, 1'b1);
    checkOutput("busy_after_2048", WW'(busy_o), WW'(1));
    for (int i = 0; i < 5; i++) begin
      in_valid_i = 1'b1;
      in_re_i = 32'hDEAD0000 + i;
      in_im_i = 32'hBEEF0000 + i;
      tick();
    end
    in_valid_i = 1'b0;
    checkOutput("overflow_set", WW'(overflow_o), WW'(1));
    checkOutput("busy_still_set", WW'(busy_o), WW'(1));
    ready_mode = 1;
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      if (out_valid_o && out_last_o && out_scale_o == 0) found = 1'b1;
      else tick();
    end
    checkOutput("found_last_frame0", WW'(found), WW'(1));
    checkOutput("busy_before_release", WW'(busy_o), WW'(1));
    tick();
    checkOutput("busy_after_release", WW'(busy_o), '0);
    waitDrain("stall_drain");
    applyStimulus(131072, N, 2, 1'b1);
    waitDrain("post_overflow_drain");
    checkOutput("overflow_sticky", WW'(overflow_o), WW'(1));

    // Reset mid-frame, then a fresh frame
    applyStimulus(200000, 300, 0, 1'b0);
    doReset("rst3");
    repeat (5) tick();
    checkOutput("no_partial_output", WW'(out_valid_o), '0);
    applyStimulus(300000, N, 0, 1'b1);
    waitDrain("fresh_drain");
    checkOutput("fresh_overflow", WW'(overflow_o), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
